// File: rtl/multi_alarm_clock.sv
// 24-hour BCD real-time clock with N_ALARMS independently armed alarm channels (snooze, auto-timeout).
// Optional 12-hour display when MULTI_ALARM_CLOCK_TWELVE_HOUR_EN is defined; default build is 24-hour with pm tied 0.
module multi_alarm_clock #(
  parameter int unsigned CLK_PER_SEC  = 1,
  parameter int unsigned N_ALARMS     = 4,
  parameter int unsigned SNOOZE_MIN   = 5,
  parameter int unsigned RING_MAX_SEC = 60,
  localparam int unsigned AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_time,
  input  logic                ld_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [1:0]          in_h2,
  input  logic [3:0]          in_h1,
  input  logic [3:0]          in_m2,
  input  logic [3:0]          in_m1,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                stop,
  input  logic                snooze,
  output logic [1:0]          o_h2,
  output logic [3:0]          o_h1,
  output logic [3:0]          o_m2,
  output logic [3:0]          o_m1,
  output logic [3:0]          o_s2,
  output logic [3:0]          o_s1,
  output logic                pm,
  output logic                sec_tick,
  output logic                ring,
  output logic [AW-1:0]       ring_id
);

  localparam int unsigned CW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} ch_state_e;

  logic [CW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [4:0]    h_q, h_d, h_nx;
  logic [5:0]    m_q, m_d, m_nx;
  logic [5:0]    s_q, s_d, s_nx;

  ch_state_e     st_q   [N_ALARMS];
  ch_state_e     st_d   [N_ALARMS];
  logic [7:0]    rcnt_q [N_ALARMS];
  logic [7:0]    rcnt_d [N_ALARMS];
  logic [4:0]    alh_q  [N_ALARMS];
  logic [4:0]    alh_d  [N_ALARMS];
  logic [5:0]    alm_q  [N_ALARMS];
  logic [5:0]    alm_d  [N_ALARMS];
  logic [4:0]    snh_q  [N_ALARMS];
  logic [4:0]    snh_d  [N_ALARMS];
  logic [5:0]    snm_q  [N_ALARMS];
  logic [5:0]    snm_d  [N_ALARMS];

  logic [5:0]    in_hour;
  logic [7:0]    in_min;
  logic          ld_ok, ld_t, ld_a, tick_eff;
  logic [6:0]    sm_sum;
  logic [4:0]    tgt_h;
  logic [5:0]    tgt_m;
  logic [4:0]    disp_h;

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  always_comb begin
    in_hour  = 6'({4'b0, in_h2}) * 6'd10 + {2'b0, in_h1};
    in_min   = {4'b0, in_m2} * 8'd10 + {4'b0, in_m1};
    ld_ok    = (in_h1 <= 4'd9) && (in_m2 <= 4'd9) && (in_m1 <= 4'd9) &&
               (in_hour <= 6'd23) && (in_min <= 8'd59);
    ld_t     = ld_time & ld_ok;
    ld_a     = ld_alarm & ld_ok & (32'(alarm_sel) < N_ALARMS);
    // A valid time load swallows any tick pending in the same cycle.
    tick_eff = tick_q & ~ld_t;
  end

  always_comb begin
    s_nx = s_q + 6'd1;
    m_nx = m_q;
    h_nx = h_q;
    if (s_q == 6'd59) begin
      s_nx = '0;
      if (m_q == 6'd59) begin
        m_nx = '0;
        h_nx = (h_q == 5'd23) ? '0 : h_q + 5'd1;
      end else begin
        m_nx = m_q + 6'd1;
      end
    end
  end

  always_comb begin
    sm_sum = {1'b0, m_q} + 7'(SNOOZE_MIN);
    tgt_h  = h_q;
    tgt_m  = sm_sum[5:0];
    if (sm_sum >= 7'd60) begin
      tgt_m = 6'(sm_sum - 7'd60);
      tgt_h = (h_q == 5'd23) ? '0 : h_q + 5'd1;
    end
  end

  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    h_d    = h_q;
    m_d    = m_q;
    s_d    = s_q;
    if (ld_t) begin
      pre_d = '0;
      h_d   = in_hour[4:0];
      m_d   = in_min[5:0];
      s_d   = '0;
    end else begin
      tick_d = (pre_q == CW'(CLK_PER_SEC - 1));
      pre_d  = tick_d ? '0 : pre_q + CW'(1);
      if (tick_eff) begin
        h_d = h_nx;
        m_d = m_nx;
        s_d = s_nx;
      end
    end
  end

  // Lowest-index ringing channel owns ring_id and receives stop/snooze.
  always_comb begin
    ring    = 1'b0;
    ring_id = '0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (st_q[N_ALARMS-1-i] == ST_RING) begin
        ring    = 1'b1;
        ring_id = AW'(N_ALARMS - 1 - i);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];
      alh_d[i]  = alh_q[i];
      alm_d[i]  = alm_q[i];
      snh_d[i]  = snh_q[i];
      snm_d[i]  = snm_q[i];
      if (ld_a && (alarm_sel == AW'(i))) begin
        alh_d[i] = in_hour[4:0];
        alm_d[i] = in_min[5:0];
      end
      if (!alarm_en[i]) begin
        st_d[i] = ST_IDLE;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            if (tick_eff && (s_nx == '0) && (h_nx == alh_q[i]) && (m_nx == alm_q[i])) begin
              st_d[i]   = ST_RING;
              rcnt_d[i] = '0;
            end
          end
          ST_RING: begin
            if (stop && (ring_id == AW'(i))) begin
              st_d[i] = ST_IDLE;
            end else if (snooze && (ring_id == AW'(i))) begin
              st_d[i]  = ST_SNOOZE;
              snh_d[i] = tgt_h;
              snm_d[i] = tgt_m;
            end else if (tick_eff) begin
              if (rcnt_q[i] == 8'(RING_MAX_SEC - 1)) st_d[i] = ST_IDLE;
              else rcnt_d[i] = rcnt_q[i] + 8'd1;
            end
          end
          ST_SNOOZE: begin
            if (tick_eff && (s_nx == '0) && (h_nx == snh_q[i]) && (m_nx == snm_q[i])) begin
              st_d[i]   = ST_RING;
              rcnt_d[i] = '0;
            end
          end
          default: st_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        st_q[i]   <= ST_IDLE;
        rcnt_q[i] <= '0;
        alh_q[i]  <= '0;
        alm_q[i]  <= '0;
        snh_q[i]  <= '0;
        snm_q[i]  <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      m_q    <= m_d;
      s_q    <= s_d;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
        alh_q[i]  <= alh_d[i];
        alm_q[i]  <= alm_d[i];
        snh_q[i]  <= snh_d[i];
        snm_q[i]  <= snm_d[i];
      end
    end
  end

`ifdef MULTI_ALARM_CLOCK_TWELVE_HOUR_EN
  always_comb begin
    if (h_q == 5'd0)       disp_h = 5'd12;
    else if (h_q > 5'd12)  disp_h = h_q - 5'd12;
    else                   disp_h = h_q;
    pm = (h_q >= 5'd12);
  end
`else
  always_comb begin
    disp_h = h_q;
    pm     = 1'b0;
  end
`endif

  always_comb begin
    o_h2     = 2'(tens({1'b0, disp_h}));
    o_h1     = ones({1'b0, disp_h});
    o_m2     = tens(m_q);
    o_m1     = ones(m_q);
    o_s2     = tens(s_q);
    o_s1     = ones(s_q);
    sec_tick = tick_q;
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock with CLK_PER_SEC=4 and four channels.
module tb_multi_alarm_clock;
  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       reset, ld_time, ld_alarm, stop, snooze;
  logic [1:0] alarm_sel;
  logic [1:0] in_h2;
  logic [3:0] in_h1, in_m2, in_m1;
  logic [3:0] alarm_en;
  logic [1:0] o_h2;
  logic [3:0] o_h1, o_m2, o_m1, o_s2, o_s1;
  logic       pm, sec_tick, ring;
  logic [1:0] ring_id;
  logic [21:0] disp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign disp = {o_h2, o_h1, o_m2, o_m1, o_s2, o_s1};

  multi_alarm_clock #(
    .CLK_PER_SEC (CPS),
    .N_ALARMS    (4),
    .SNOOZE_MIN  (5),
    .RING_MAX_SEC(60)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_time  (ld_time),
    .ld_alarm (ld_alarm),
    .alarm_sel(alarm_sel),
    .in_h2    (in_h2),
    .in_h1    (in_h1),
    .in_m2    (in_m2),
    .in_m1    (in_m1),
    .alarm_en (alarm_en),
    .stop     (stop),
    .snooze   (snooze),
    .o_h2     (o_h2),
    .o_h1     (o_h1),
    .o_m2     (o_m2),
    .o_m1     (o_m1),
    .o_s2     (o_s2),
    .o_s1     (o_s1),
    .pm       (pm),
    .sec_tick (sec_tick),
    .ring     (ring),
    .ring_id  (ring_id)
  );

  task automatic load_time(input logic [1:0] h2, input logic [3:0] h1, m2, m1);
    in_h2 = h2; in_h1 = h1; in_m2 = m2; in_m1 = m1;
    ld_time = 1'b1;
    @(negedge clk);
    ld_time = 1'b0;
  endtask

  task automatic load_alarm(input logic [1:0] sel, input logic [1:0] h2, input logic [3:0] h1, m2, m1);
    in_h2 = h2; in_h1 = h1; in_m2 = m2; in_m1 = m1;
    alarm_sel = sel;
    ld_alarm  = 1'b1;
    @(negedge clk);
    ld_alarm  = 1'b0;
  endtask

  task automatic pulse(input logic st, input logic sn);
    stop = st; snooze = sn;
    @(negedge clk);
    stop = 1'b0; snooze = 1'b0;
  endtask

  // Each iteration ends on the negedge just after the time has advanced by one second.
  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      int cnt = 0;
      while (sec_tick !== 1'b1 && cnt < 4 * CPS) begin
        @(negedge clk);
        cnt++;
      end
      if (sec_tick !== 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL tick_timeout: sec_tick=%b after %0d cycles, required 1", sec_tick, cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++; if (disp !== 22'd0) begin n_fail++; $display("FAIL reset_time: got %h, required 0", disp); end
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL reset_ring: got %b, required 0", ring); end
    n_tests++; if (ring_id !== 2'd0) begin n_fail++; $display("FAIL reset_ring_id: got %0d, required 0", ring_id); end
    n_tests++; if (sec_tick !== 1'b0) begin n_fail++; $display("FAIL reset_sec_tick: got %b, required 0", sec_tick); end
    n_tests++; if (pm !== 1'b0) begin n_fail++; $display("FAIL reset_pm: got %b, required 0", pm); end
    reset = 1'b0;
  endtask

  task automatic test_prescaler_rollover;
    load_time(2'd2, 4'd3, 4'd5, 4'd9);
    n_tests++; if (disp !== {2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL load_2359: got %h, required 23:59:00", disp); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_tests++;
      if (sec_tick !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL tick_period[%0d]: got %b, required %b", k, sec_tick, (k % 4) == 0);
      end
    end
    n_tests++; if (disp !== {2'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1}) begin
      n_fail++; $display("FAIL first_second: got %h, required 23:59:01", disp); end
    tick_n(59);
    n_tests++; if (disp !== 22'd0) begin
      n_fail++; $display("FAIL midnight_wrap: got %h, required 00:00:00", disp); end
  endtask

  task automatic test_load_validation;
    load_time(2'd2, 4'd5, 4'd1, 4'd0);
    load_time(2'd1, 4'd2, 4'd6, 4'hA);
    n_tests++; if (disp !== 22'd0) begin
      n_fail++; $display("FAIL invalid_loads: got %h, required 00:00:00", disp); end
  endtask

  task automatic test_multi_ring;
    load_alarm(2'd0, 2'd0, 4'd7, 4'd0, 4'd0);
    load_alarm(2'd2, 2'd0, 4'd7, 4'd0, 4'd0);
    alarm_en = 4'b0101;
    load_time(2'd0, 4'd6, 4'd5, 4'd9);
    tick_n(59);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL early_ring: got %b, required 0", ring); end
    tick_n(1);
    n_tests++; if (disp !== {2'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL time_0700: got %h, required 07:00:00", disp); end
    n_tests++; if (ring !== 1'b1 || ring_id !== 2'd0) begin
      n_fail++; $display("FAIL ring_ch0: got ring=%b id=%0d, required ring=1 id=0", ring, ring_id); end
    pulse(1'b1, 1'b0);
    n_tests++; if (ring !== 1'b1 || ring_id !== 2'd2) begin
      n_fail++; $display("FAIL ring_ch2: got ring=%b id=%0d, required ring=1 id=2", ring, ring_id); end
    pulse(1'b1, 1'b0);
    n_tests++; if (ring !== 1'b0 || ring_id !== 2'd0) begin
      n_fail++; $display("FAIL all_stopped: got ring=%b id=%0d, required ring=0 id=0", ring, ring_id); end
    @(negedge clk);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL retrigger_same_sec: got %b, required 0", ring); end
    tick_n(1);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL retrigger_next_sec: got %b, required 0", ring); end
    alarm_en = 4'b0000;
  endtask

  task automatic test_snooze;
    load_alarm(2'd1, 2'd0, 4'd6, 4'd5, 4'd8);
    alarm_en = 4'b0010;
    load_time(2'd0, 4'd6, 4'd5, 4'd7);
    tick_n(60);
    n_tests++; if (ring !== 1'b1 || ring_id !== 2'd1) begin
      n_fail++; $display("FAIL ring_ch1: got ring=%b id=%0d, required ring=1 id=1", ring, ring_id); end
    tick_n(10);
    n_tests++; if (disp !== {2'd0, 4'd6, 4'd5, 4'd8, 4'd1, 4'd0} || ring !== 1'b1) begin
      n_fail++; $display("FAIL pre_snooze: got %h ring=%b, required 06:58:10 ring=1", disp, ring); end
    pulse(1'b0, 1'b1);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snoozed: got %b, required 0", ring); end
    tick_n(289);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL snooze_early: got %b, required 0", ring); end
    tick_n(1);
    n_tests++; if (disp !== {2'd0, 4'd7, 4'd0, 4'd3, 4'd0, 4'd0} || ring !== 1'b1 || ring_id !== 2'd1) begin
      n_fail++; $display("FAIL snooze_ring: got %h ring=%b id=%0d, required 07:03:00 ring=1 id=1", disp, ring, ring_id); end
    tick_n(59);
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ring_before_timeout: got %b, required 1", ring); end
    tick_n(1);
    n_tests++; if (disp !== {2'd0, 4'd7, 4'd0, 4'd4, 4'd0, 4'd0} || ring !== 1'b0) begin
      n_fail++; $display("FAIL auto_stop: got %h ring=%b, required 07:04:00 ring=0", disp, ring); end
    alarm_en = 4'b0000;
  endtask

  task automatic test_stop_wins;
    load_alarm(2'd3, 2'd0, 4'd8, 4'd0, 4'd0);
    alarm_en = 4'b1000;
    load_time(2'd0, 4'd7, 4'd5, 4'd9);
    tick_n(60);
    n_tests++; if (ring !== 1'b1 || ring_id !== 2'd3) begin
      n_fail++; $display("FAIL ring_ch3: got ring=%b id=%0d, required ring=1 id=3", ring, ring_id); end
    pulse(1'b1, 1'b1);
    n_tests++; if (ring !== 1'b0) begin n_fail++; $display("FAIL stop_snooze: got %b, required 0", ring); end
    tick_n(300);
    n_tests++; if (disp !== {2'd0, 4'd8, 4'd0, 4'd5, 4'd0, 4'd0} || ring !== 1'b0) begin
      n_fail++; $display("FAIL stop_won: got %h ring=%b, required 08:05:00 ring=0", disp, ring); end
    load_alarm(2'd3, 2'd0, 4'd8, 4'd0, 4'd6);
    tick_n(60);
    n_tests++; if (ring !== 1'b1 || ring_id !== 2'd3) begin
      n_fail++; $display("FAIL ring_ch3_again: got ring=%b id=%0d, required ring=1 id=3", ring, ring_id); end
    pulse(1'b0, 1'b1);
    alarm_en = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    alarm_en = 4'b1000;
    tick_n(300);
    n_tests++; if (disp !== {2'd0, 4'd8, 4'd1, 4'd1, 4'd0, 4'd0} || ring !== 1'b0) begin
      n_fail++; $display("FAIL disarm_snooze: got %h ring=%b, required 08:11:00 ring=0", disp, ring); end
    alarm_en = 4'b0000;
  endtask

  task automatic test_display;
`ifdef MULTI_ALARM_CLOCK_TWELVE_HOUR_EN
    load_time(2'd0, 4'd0, 4'd3, 4'd0);
    n_tests++; if (disp[21:8] !== {2'd1, 4'd2, 4'd3, 4'd0} || pm !== 1'b0) begin
      n_fail++; $display("FAIL disp_0030: got %h pm=%b, required 12:30 pm=0", disp[21:8], pm); end
    load_time(2'd1, 4'd2, 4'd3, 4'd0);
    n_tests++; if (disp[21:8] !== {2'd1, 4'd2, 4'd3, 4'd0} || pm !== 1'b1) begin
      n_fail++; $display("FAIL disp_1230: got %h pm=%b, required 12:30 pm=1", disp[21:8], pm); end
    load_time(2'd1, 4'd3, 4'd0, 4'd5);
    n_tests++; if (disp[21:8] !== {2'd0, 4'd1, 4'd0, 4'd5} || pm !== 1'b1) begin
      n_fail++; $display("FAIL disp_1305: got %h pm=%b, required 01:05 pm=1", disp[21:8], pm); end
`else
    load_time(2'd0, 4'd0, 4'd3, 4'd0);
    n_tests++; if (disp[21:8] !== {2'd0, 4'd0, 4'd3, 4'd0} || pm !== 1'b0) begin
      n_fail++; $display("FAIL disp_0030: got %h pm=%b, required 00:30 pm=0", disp[21:8], pm); end
    load_time(2'd1, 4'd3, 4'd0, 4'd5);
    n_tests++; if (disp[21:8] !== {2'd1, 4'd3, 4'd0, 4'd5} || pm !== 1'b0) begin
      n_fail++; $display("FAIL disp_1305: got %h pm=%b, required 13:05 pm=0", disp[21:8], pm); end
`endif
  endtask

  task automatic test_reset_mid_ring;
    alarm_en = 4'b0001;
    load_time(2'd0, 4'd6, 4'd5, 4'd9);
    tick_n(60);
    n_tests++; if (ring !== 1'b1) begin n_fail++; $display("FAIL ring_before_reset: got %b, required 1", ring); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (ring !== 1'b0 || ring_id !== 2'd0 || disp !== 22'd0) begin
      n_fail++; $display("FAIL async_reset: got ring=%b id=%0d time=%h, required 0 0 0", ring, ring_id, disp); end
    @(negedge clk);
    alarm_en = 4'b0000;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_time = 1'b0; ld_alarm = 1'b0; stop = 1'b0; snooze = 1'b0;
    alarm_sel = 2'd0; in_h2 = 2'd0; in_h1 = 4'd0; in_m2 = 4'd0; in_m1 = 4'd0;
    alarm_en = 4'b0000;
    test_reset;
    test_prescaler_rollover;
    test_load_validation;
    test_multi_ring;
    test_snooze;
    test_stop_wins;
    test_display;
    test_reset_mid_ring;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
- 24-hour BCD real-time clock with N independently programmable alarm channels.
- Includes a seconds prescaler, per-channel arm/snooze/auto-timeout, and load validation.
- Next-generation replacement for the single-alarm clock; sits between the front-panel input decoder and the display/buzzer drivers.

Parameters:
- CLK_PER_SEC, 1, clk cycles per second; must be >= 1.
- N_ALARMS, 4, number of alarm channels; must be >= 1.
- SNOOZE_MIN, 5, snooze interval in minutes; range 1..59.
- RING_MAX_SEC, 60, seconds a channel rings before auto-stop; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- ld_time  in  1  load clock time from in_* (seconds cleared).
- ld_alarm  in  1  load alarm time of channel alarm_sel from in_*.
- alarm_sel  in  AW  target channel for ld_alarm; AW = (N_ALARMS>1) ? $clog2(N_ALARMS) : 1.
- in_h2  in  2  hour tens, BCD.
- in_h1  in  4  hour units, BCD.
- in_m2  in  4  minute tens, BCD.
- in_m1  in  4  minute units, BCD.
- alarm_en  in  N_ALARMS  per-channel arm, level.
- stop  in  1  stop the reported ringing channel.
- snooze  in  1  snooze the reported ringing channel.
- o_h2  out  2  hour tens, BCD.
- o_h1, o_m2, o_m1, o_s2, o_s1  out  4 each  remaining BCD time digits.
- pm  out  1  PM flag (12-hour mode only).
- sec_tick  out  1  one-cycle pulse per second.
- ring  out  1  OR of all channels in RING.
- ring_id  out  AW  lowest-index channel in RING; 0 when ring=0.

Behaviour:
- Reset values:
  - time 00:00:00, prescaler 0.
  - all alarm times 00:00, all channels IDLE.
  - ring=0, ring_id=0, sec_tick=0, pm=0.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1.
  - sec_tick is registered; it is high for the cycle after the count reaches CLK_PER_SEC-1.
  - CLK_PER_SEC=1 gives sec_tick high every cycle after reset.
- Time keeping:
  - Internal binary h(5b), m(6b), s(6b), advanced on each tick.
  - s wraps 59->0 and carries to m; m wraps 59->0 and carries to h; h wraps 23->0.
  - Output digits are combinational from the registered time, so there is zero added latency.
- Load validation:
  - ld_time and ld_alarm are ignored entirely if the hour is > 23, the minute is > 59, or any digit > 9.
- ld_time:
  - Next cycle the time is the loaded value with s=0.
  - Prescaler resets to 0.
  - The tick pending in the load cycle is discarded.
- ld_alarm:
  - Writes the alarm time of channel alarm_sel.
  - An out-of-range alarm_sel is ignored.
  - Does not change channel state.
- Simultaneous ld_time and ld_alarm: both take effect.
- Channel FSM (per channel i):
  - IDLE -> RING: on a tick whose new time equals alarm[i]:00 and alarm_en[i]=1.
  - Matching happens only on tick edges, so stop never causes a re-trigger within the same second.
  - RING: a ring counter increments per tick. At RING_MAX_SEC ticks the channel goes to IDLE.
  - RING -> IDLE: on stop, when i == ring_id.
  - RING -> SNOOZE: on snooze, when i == ring_id. The snooze target is (current h:m + SNOOZE_MIN) mod 24h, with :00 seconds.
  - SNOOZE -> RING: on the tick where the new time equals the snooze target. Ring counter is cleared.
  - alarm_en[i]=0 forces IDLE next cycle from any state.
  - stop and snooze asserted together: stop wins.
  - A channel entering RING while another rings leaves ring_id unchanged unless its index is lower.
  - ld_time does not change FSM states; a snooze target is still compared against the new time.
- reset mid-ring: ring drops asynchronously; all state returns to reset values.

Optional Feature:
- Macro: MULTI_ALARM_CLOCK_TWELVE_HOUR_EN.
- When defined, the display is in 12-hour format:
  - h=0 shows 12 with pm=0.
  - h=1..11 shows 1..11 with pm=0.
  - h=12 shows 12 with pm=1.
  - h=13..23 shows 1..11 with pm=1.
- Loads and alarms remain in 24-hour values.
- When undefined: 24-hour display and pm tied 0.

Test Plan:
- CLK_PER_SEC=4, reset, ld_time 23:59 -> sec_tick every 4th cycle; after 60 ticks the display is 00:00:00.
- ld_time 25:10 and ld_time 12:6A (digit >9) -> both ignored, time unchanged.
- Alarms: ch0 = 07:00, ch2 = 07:00; arm both; time reaches 07:00:00:
  - ring=1, ring_id=0.
  - stop -> ring_id=2.
  - stop -> ring=0, and there is no re-trigger during 07:00:00.
- ch1 = 06:58, SNOOZE_MIN=5, ring, then snooze at 06:58:10:
  - ring=0.
  - ring reasserts at 07:03:00.
  - Auto-stop after 60 ticks, at 07:04:00.
- Ringing ch3 with stop and snooze in the same cycle -> IDLE (stop wins); drop alarm_en[3] while SNOOZE -> no later ring.
- With the macro defined, time 00:30 / 12:30 / 13:05 -> display 12:30 pm=0 / 12:30 pm=1 / 01:05 pm=1.
